// File: rtl/nibble_serial_pkg.sv
// Purpose : shared constants and state encoding for the slice-serial adder.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package nibble_serial_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_SLICE  = 4;
    localparam int DEF_NSLICE = DEF_WIDTH / DEF_SLICE;

    // Index width for a slice counter; a single-slice adder still needs
    // a one-bit counter so the register never collapses to zero width.
    function automatic int idx_width(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

    localparam int DEF_IDX_W = idx_width(DEF_NSLICE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_adder_slice.sv
// Purpose : combinational SLICE-bit ripple adder built from half-add pairs.
// Latency : 0 cycles (purely combinational).
// Backpressure: none; output follows inputs.
//
// Ports: x, y  - SLICE-bit addends
//        ci    - carry into bit 0
//        s     - SLICE-bit sum
//        co    - carry out of the top bit
module nibble_adder_slice
    import nibble_serial_pkg::*;
#(
    parameter int SLICE = DEF_SLICE
) (
    input  logic [SLICE-1:0] x,
    input  logic [SLICE-1:0] y,
    input  logic             ci,
    output logic [SLICE-1:0] s,
    output logic             co
);

    logic [SLICE:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < SLICE; i++) begin : g_bit
        logic p;
        logic g;
        // First half-add: propagate/generate of the operand bits.
        assign p = x[i] ^ y[i];
        assign g = x[i] & y[i];
        // Second half-add folds in the ripple carry.
        assign s[i]   = p ^ c[i];
        assign c[i+1] = g | (p & c[i]);
    end

    assign co = c[SLICE];

endmodule

// File: rtl/nibble_serial_adder.sv
// Purpose : WIDTH-bit unsigned adder that reuses one SLICE-bit slice over NSLICE cycles.
// Latency : start sampled at E0, done pulses in the cycle after edge E_NSLICE.
// Backpressure: start is ignored while busy; the done cycle accepts a new start.
//
// Ports: clk, rst     - clock, synchronous active-high reset
//        start        - request, taken in IDLE or DONE
//        a, b, cin    - operands, captured on an accepted start
//        busy, done   - addition in progress / one-cycle result-valid pulse
//        sum, cout    - result, held after done until the next run
module nibble_serial_adder
    import nibble_serial_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDX_W  = idx_width(NSLICE);

    if (SLICE < 1 || WIDTH < SLICE || (WIDTH % SLICE) != 0) begin : g_bad_cfg
        $error("nibble_serial_adder: WIDTH must be a positive multiple of SLICE");
    end

    state_t                         state;
    logic [NSLICE-1:0][SLICE-1:0]   a_reg;
    logic [NSLICE-1:0][SLICE-1:0]   b_reg;
    logic [NSLICE-1:0][SLICE-1:0]   sum_reg;
    logic                           carry_reg;
    logic                           cout_reg;
    logic [IDX_W-1:0]               idx;

    logic [SLICE-1:0]               sl_s;
    logic                           sl_co;
    logic                           last_slice;

    // Slice mux: the packed 2-D layout makes slice idx a plain array index.
    nibble_adder_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .x  (a_reg[idx]),
        .y  (b_reg[idx]),
        .ci (carry_reg),
        .s  (sl_s),
        .co (sl_co)
    );

    assign last_slice = (idx == IDX_W'(NSLICE - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            idx       <= '0;
        end else begin
            case (state)
                // DONE behaves like IDLE for request acceptance, which is
                // what gives back-to-back throughput of NSLICE+1 cycles.
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= cin;
                        idx       <= '0;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    sum_reg[idx] <= sl_s;
                    carry_reg    <= sl_co;
                    idx          <= idx + IDX_W'(1);
                    if (last_slice) begin
                        cout_reg <= sl_co;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;

endmodule
